// File: rtl/cache_rd_arbiter_pkg.sv
// Shared types for the cache refill read arbiter: FSM state encoding and requester IDs.
package cache_rd_arbiter_pkg;

    localparam int unsigned LINE_OFFSET_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10
    } arb_state_e;

    localparam logic ARB_DCACHE = 1'b0;
    localparam logic ARB_ICACHE = 1'b1;

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational 2-way requester picker; fixed priority DCache over ICache,
// or round-robin on ties when CACHE_ARB_RR_EN is defined.
module cache_arb_pick
    import cache_rd_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic any,
    output logic winner
);

    assign any = req0 | req1;

`ifdef CACHE_ARB_RR_EN
    // On a tie the requester not served last time wins.
    always_comb begin
        winner = req0 ? ARB_DCACHE : ARB_ICACHE;
        if (req0 && req1) begin
            winner = ~rr_last;
        end
    end
`else
    logic unused_rr_last;
    assign unused_rr_last = rr_last;
    assign winner         = req0 ? ARB_DCACHE : ARB_ICACHE;
`endif

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one cache-line read port between the DCache and ICache refill engines.
// Optional round-robin tie-break via CACHE_ARB_RR_EN.
module cache_rd_arbiter
    import cache_rd_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 128,
    parameter int unsigned TO_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ret_valid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ret_valid1,
    output logic [LINE_W-1:0] ret_data,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_rdy,
    input  logic              mem_ret_valid,
    input  logic [LINE_W-1:0] mem_ret_data,
    output logic              grant,
    output logic              busy,
    output logic              err_timeout
);

    localparam int unsigned CNT_W   = $clog2(TO_CYCLES + 1);
    localparam int unsigned TAG_W   = ADDR_W - LINE_OFFSET_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TO_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic             pick_any;
    logic             pick_winner;
    logic             rr_last;
    logic             take;
    logic             ret_hit;
    logic [TAG_W-1:0] sel_line;
    logic [CNT_W-1:0] wait_cnt;
    logic             unused_offset;

    cache_arb_pick u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr_last (rr_last),
        .any     (pick_any),
        .winner  (pick_winner)
    );

    assign take          = (state == ARB_IDLE) && pick_any;
    assign sel_line      = (pick_winner == ARB_ICACHE) ? addr1[ADDR_W-1:LINE_OFFSET_W]
                                                       : addr0[ADDR_W-1:LINE_OFFSET_W];
    assign unused_offset = ^{addr0[LINE_OFFSET_W-1:0], addr1[LINE_OFFSET_W-1:0]};

`ifdef CACHE_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (take) begin
            rr_last <= pick_winner;
        end
    end
`else
    assign rr_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (pick_any)      state_nxt = ARB_ISSUE;
            ARB_ISSUE: if (mem_rd_rdy)    state_nxt = ARB_WAIT;
            ARB_WAIT:  if (mem_ret_valid) state_nxt = ARB_IDLE;
            default:                      state_nxt = ARB_IDLE;
        endcase
    end

    assign busy       = (state != ARB_IDLE);
    assign mem_rd_req = (state == ARB_ISSUE);

    // Return path: a line is only accepted while waiting for it.
    assign ret_hit    = (state == ARB_WAIT) && mem_ret_valid;
    assign ret_valid0 = ret_hit && (grant == ARB_DCACHE);
    assign ret_valid1 = ret_hit && (grant == ARB_ICACHE);
    assign ret_data   = mem_ret_data;

    // Owner, line-aligned address, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= ARB_DCACHE;
            mem_rd_addr <= '0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (take) begin
                grant       <= pick_winner;
                mem_rd_addr <= {sel_line, LINE_OFFSET_W'(0)};
            end
            if ((state == ARB_ISSUE) && mem_rd_rdy) begin
                wait_cnt <= '0;
            end else if ((state == ARB_WAIT) && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if ((state == ARB_WAIT) && !mem_ret_valid && (wait_cnt == CNT_LAST)) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Self-checking bench for cache_rd_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_cache_rd_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned LINE_W    = 128;
    localparam int unsigned TO_CYCLES = 8;

    logic              clk;
    logic              rst;
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              ret_valid0, ret_valid1;
    logic [LINE_W-1:0] ret_data;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_rdy;
    logic              mem_ret_valid;
    logic [LINE_W-1:0] mem_ret_data;
    logic              grant, busy, err_timeout;

    int checks   = 0;
    int failures = 0;

    cache_rd_arbiter #(
        .ADDR_W    (ADDR_W),
        .LINE_W    (LINE_W),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req0          (req0),
        .addr0         (addr0),
        .ret_valid0    (ret_valid0),
        .req1          (req1),
        .addr1         (addr1),
        .ret_valid1    (ret_valid1),
        .ret_data      (ret_data),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_rdy    (mem_rd_rdy),
        .mem_ret_valid (mem_ret_valid),
        .mem_ret_data  (mem_ret_data),
        .grant         (grant),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 4ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_data = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        mem_rd_rdy = 1'b0; mem_ret_valid = 1'b1; mem_ret_data = '1;
        step();
        step();
        #4;
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (grant !== 1'b0)       begin failures++; $display("FAIL reset_grant got=%0b exp=0", grant); end
        checks++; if (mem_rd_req !== 1'b0)  begin failures++; $display("FAIL reset_mem_rd_req got=%0b exp=0", mem_rd_req); end
        checks++; if (mem_rd_addr !== '0)   begin failures++; $display("FAIL reset_mem_rd_addr got=%0h exp=0", mem_rd_addr); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_timeout); end
        checks++; if ({ret_valid0, ret_valid1} !== 2'b00) begin failures++; $display("FAIL reset_ret_valid got=%0b exp=00", {ret_valid0, ret_valid1}); end
        step();
        rst = 1'b0;
        #4;
        checks++; if ({ret_valid0, ret_valid1, busy} !== 3'b000) begin failures++; $display("FAIL post_reset_ret got=%0b exp=000", {ret_valid0, ret_valid1, busy}); end
        step();
        mem_ret_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [LINE_W-1:0] line;
        line = {$urandom, $urandom, $urandom, $urandom};
        req0 = 1'b1; addr0 = 32'h1FC0_0004;
        #4;
        checks++; if (mem_rd_req !== 1'b0) begin failures++; $display("FAIL basic_req_t0 got=%0b exp=0", mem_rd_req); end
        step();
        mem_rd_rdy = 1'b1;
        #4;
        checks++; if (mem_rd_req !== 1'b1)           begin failures++; $display("FAIL basic_req_t1 got=%0b exp=1", mem_rd_req); end
        checks++; if (mem_rd_addr !== 32'h1FC0_0000) begin failures++; $display("FAIL basic_addr got=%0h exp=1fc00000", mem_rd_addr); end
        checks++; if ({busy, grant} !== 2'b10)       begin failures++; $display("FAIL basic_busy_grant got=%0b exp=10", {busy, grant}); end
        step();
        mem_rd_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++; if ({mem_rd_req, ret_valid0, ret_valid1} !== 3'b000) begin failures++; $display("FAIL basic_wait%0d got=%0b exp=000", i, {mem_rd_req, ret_valid0, ret_valid1}); end
            step();
        end
        mem_ret_valid = 1'b1; mem_ret_data = line;
        #4;
        checks++; if ({ret_valid0, ret_valid1} !== 2'b10) begin failures++; $display("FAIL basic_ret got=%0b exp=10", {ret_valid0, ret_valid1}); end
        checks++; if (ret_data !== line) begin failures++; $display("FAIL basic_data got=%0h exp=%0h", ret_data, line); end
        step();
        mem_ret_valid = 1'b0; req0 = 1'b0;
        #4;
        checks++; if ({ret_valid0, busy} !== 2'b00) begin failures++; $display("FAIL basic_single_pulse got=%0b exp=00", {ret_valid0, busy}); end
        step();
    endtask

    task automatic test_tie();
        logic [ADDR_W-1:0] a [2];
        int exp_owner [$];
        int waited;
        apply_reset();
        a[0] = 32'h0000_1238;
        a[1] = 32'h8000_00FF;
`ifdef CACHE_ARB_RR_EN
        exp_owner = '{0, 1, 0};
`else
        exp_owner = '{0, 1};
`endif
        req0 = 1'b1; addr0 = a[0]; req1 = 1'b1; addr1 = a[1];
        foreach (exp_owner[k]) begin
            waited = 0;
            #4;
            while (mem_rd_req !== 1'b1 && waited < 6) begin
                step();
                #4;
                waited++;
            end
            checks++; if (mem_rd_req !== 1'b1) begin failures++; $display("FAIL tie_issue%0d got=%0b exp=1", k, mem_rd_req); end
            checks++; if (grant !== 1'(exp_owner[k])) begin failures++; $display("FAIL tie_grant%0d got=%0b exp=%0d", k, grant, exp_owner[k]); end
            checks++; if (mem_rd_addr !== (a[exp_owner[k]] & 32'hFFFF_FFF0)) begin failures++; $display("FAIL tie_addr%0d got=%0h exp=%0h", k, mem_rd_addr, a[exp_owner[k]] & 32'hFFFF_FFF0); end
            mem_rd_rdy = 1'b1;
            step();
            mem_rd_rdy = 1'b0; mem_ret_valid = 1'b1;
            #4;
            checks++; if ({ret_valid0, ret_valid1} !== ((exp_owner[k] == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL tie_ret%0d got=%0b owner=%0d", k, {ret_valid0, ret_valid1}, exp_owner[k]); end
            step();
            mem_ret_valid = 1'b0;
`ifndef CACHE_ARB_RR_EN
            if (exp_owner[k] == 0) req0 = 1'b0; else req1 = 1'b0;
`endif
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
    endtask

    task automatic test_rdy_stall();
        logic [ADDR_W-1:0] a;
        a = $urandom;
        req1 = 1'b1; addr1 = a;
        step();
        for (int i = 0; i < 5; i++) begin
            mem_rd_rdy = 1'b0; mem_ret_valid = 1'b1;
            #4;
            checks++; if (mem_rd_req !== 1'b1) begin failures++; $display("FAIL stall_req%0d got=%0b exp=1", i, mem_rd_req); end
            checks++; if (mem_rd_addr !== (a & 32'hFFFF_FFF0)) begin failures++; $display("FAIL stall_addr%0d got=%0h exp=%0h", i, mem_rd_addr, a & 32'hFFFF_FFF0); end
            checks++; if ({ret_valid0, ret_valid1} !== 2'b00) begin failures++; $display("FAIL stall_no_wait%0d got=%0b exp=00", i, {ret_valid0, ret_valid1}); end
            step();
        end
        mem_rd_rdy = 1'b1; mem_ret_valid = 1'b0;
        step();
        mem_rd_rdy = 1'b0; mem_ret_valid = 1'b1;
        #4;
        checks++; if ({ret_valid0, ret_valid1} !== 2'b01) begin failures++; $display("FAIL stall_ret got=%0b exp=01", {ret_valid0, ret_valid1}); end
        step();
        mem_ret_valid = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_ret_idle();
        for (int i = 0; i < 4; i++) begin
            mem_ret_valid = 1'b1;
            #4;
            checks++; if ({ret_valid0, ret_valid1, busy} !== 3'b000) begin failures++; $display("FAIL idle_ret%0d got=%0b exp=000", i, {ret_valid0, ret_valid1, busy}); end
            step();
        end
        mem_ret_valid = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        req0 = 1'b1; addr0 = 32'hDEAD_BEEF;
        step();
        mem_rd_rdy = 1'b1;
        step();
        mem_rd_rdy = 1'b0;
        #4;
        checks++; if ({busy, mem_rd_req} !== 2'b10) begin failures++; $display("FAIL rstwait_in_wait got=%0b exp=10", {busy, mem_rd_req}); end
        step();
        rst = 1'b1; req0 = 1'b0;
        step();
        rst = 1'b0;
        #4;
        checks++; if ({busy, mem_rd_req} !== 2'b00) begin failures++; $display("FAIL rstwait_idle got=%0b exp=00", {busy, mem_rd_req}); end
        checks++; if (mem_rd_addr !== '0) begin failures++; $display("FAIL rstwait_addr got=%0h exp=0", mem_rd_addr); end
        step();
        mem_ret_valid = 1'b1;
        #4;
        checks++; if ({ret_valid0, ret_valid1} !== 2'b00) begin failures++; $display("FAIL rstwait_late_ret got=%0b exp=00", {ret_valid0, ret_valid1}); end
        step();
        mem_ret_valid = 1'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        req1 = 1'b1; addr1 = 32'h0000_4440;
        step();
        mem_rd_rdy = 1'b1;
        step();
        mem_rd_rdy = 1'b0;
        for (int i = 0; i < int'(TO_CYCLES); i++) begin
            #4;
            checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_early%0d got=%0b exp=0", i, err_timeout); end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++; if ({err_timeout, busy} !== 2'b11) begin failures++; $display("FAIL timeout_set%0d got=%0b exp=11", i, {err_timeout, busy}); end
            step();
        end
        mem_ret_valid = 1'b1;
        #4;
        checks++; if ({ret_valid1, err_timeout} !== 2'b11) begin failures++; $display("FAIL timeout_late_ret got=%0b exp=11", {ret_valid1, err_timeout}); end
        step();
        mem_ret_valid = 1'b0; req1 = 1'b0;
        #4;
        checks++; if ({err_timeout, busy} !== 2'b10) begin failures++; $display("FAIL timeout_sticky got=%0b exp=10", {err_timeout, busy}); end
        step();
    endtask

    // Transaction-level model: one outstanding line at a time, issue then wait.
    task automatic test_random();
        bit                pend [2];
        logic [ADDR_W-1:0] paddr [2];
        bit                m_act, m_hs, m_err, m_rr;
        int                m_own, m_wait, win;
        logic [ADDR_W-1:0] m_addr;
        bit                e_r0, e_r1;
        apply_reset();
        pend = '{1'b0, 1'b0};
        paddr = '{32'h0, 32'h0};
        m_act = 1'b0; m_hs = 1'b0; m_err = 1'b0; m_rr = 1'b1;
        m_own = 0; m_wait = 0; m_addr = '0;
        repeat (1500) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1'b1;
                    paddr[i] = $urandom;
                end
            end
            req0 = pend[0] && !(m_act && m_own == 0 && $urandom_range(7) == 0);
            req1 = pend[1] && !(m_act && m_own == 1 && $urandom_range(7) == 0);
            addr0 = paddr[0]; addr1 = paddr[1];
            mem_rd_rdy    = ($urandom_range(2) != 0);
            mem_ret_valid = ($urandom_range(3) == 0);
            mem_ret_data  = {$urandom, $urandom, $urandom, $urandom};
            e_r0 = m_act && m_hs && mem_ret_valid && m_own == 0;
            e_r1 = m_act && m_hs && mem_ret_valid && m_own == 1;
            #4;
            checks++; if (busy !== m_act) begin failures++; $display("FAIL rnd_busy got=%0b exp=%0b t=%0t", busy, m_act, $time); end
            checks++; if (mem_rd_req !== (m_act && !m_hs)) begin failures++; $display("FAIL rnd_req got=%0b exp=%0b t=%0t", mem_rd_req, m_act && !m_hs, $time); end
            checks++; if (grant !== 1'(m_own)) begin failures++; $display("FAIL rnd_grant got=%0b exp=%0d t=%0t", grant, m_own, $time); end
            checks++; if (mem_rd_addr !== m_addr) begin failures++; $display("FAIL rnd_addr got=%0h exp=%0h t=%0t", mem_rd_addr, m_addr, $time); end
            checks++; if ({ret_valid0, ret_valid1} !== {e_r0, e_r1}) begin failures++; $display("FAIL rnd_ret got=%0b exp=%0b t=%0t", {ret_valid0, ret_valid1}, {e_r0, e_r1}, $time); end
            checks++; if (ret_data !== mem_ret_data) begin failures++; $display("FAIL rnd_data got=%0h exp=%0h t=%0t", ret_data, mem_ret_data, $time); end
            checks++; if (err_timeout !== m_err) begin failures++; $display("FAIL rnd_err got=%0b exp=%0b t=%0t", err_timeout, m_err, $time); end
            if (!m_act) begin
                if (req0 || req1) begin
`ifdef CACHE_ARB_RR_EN
                    win  = (req0 && req1) ? (m_rr ? 0 : 1) : (req0 ? 0 : 1);
                    m_rr = (win == 1);
`else
                    win = req0 ? 0 : 1;
`endif
                    m_act  = 1'b1;
                    m_own  = win;
                    m_addr = ((win == 0) ? addr0 : addr1) & 32'hFFFF_FFF0;
                end
            end else if (!m_hs) begin
                if (mem_rd_rdy) begin
                    m_hs = 1'b1;
                    m_wait = 0;
                end
            end else if (mem_ret_valid) begin
                pend[m_own] = 1'b0;
                m_act = 1'b0;
                m_hs  = 1'b0;
            end else begin
                m_wait++;
                if (m_wait >= int'(TO_CYCLES)) m_err = 1'b1;
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0; mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_rdy_stall();
        test_ret_idle();
        test_reset_in_wait();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
